// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32IM instruction fetch stage. It owns the PC, issues word
//            fetches over a req/gnt/rvalid handshake, buffers returns in an
//            in-order fetch queue and presents {instr, PC, PC+4} to decode.
//            Redirects from execute flush the queue and drop in-flight
//            returns through a discard counter.
// Options  : FETCH_ALIGN_CHECK_EN - adds the sticky MisalignD output and
//            blocks issue after a redirect to a non-word-aligned target.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
`ifdef FETCH_ALIGN_CHECK_EN
  ,output logic       MisalignD
`endif
);

  localparam int          AW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int          CW  = $clog2(FQ_DEPTH + 1);
  localparam int          SW  = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch state
  logic [31:0]   pc_q;
  logic [31:0]   ret_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] disc_q;

  // Fetch queue
  logic [31:0]   fq_instr_q [FQ_DEPTH];
  logic [31:0]   fq_pc_q    [FQ_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;

  logic          w_valid;
  logic          w_pop;
  logic          w_rsp_keep;
  logic          w_push;
  logic          w_issue;
  logic          w_credit;
  logic          w_misalign;
  logic [SW-1:0] w_inflight;
  logic [31:0]   w_tgt;
  logic [31:0]   pcd_d;

  // Word-aligned redirect target; the low two bits never reach the PC.
  assign w_tgt = PCTargetE & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  // Sticky misalignment flag, updated only by redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (PCSrcE) begin
      misalign_q <= |PCTargetE[1:0];
    end
  end

  assign w_misalign = misalign_q;
  assign MisalignD  = misalign_q;
`else
  assign w_misalign = 1'b0;
`endif

  // Queue/return bookkeeping. The head leaving this cycle frees its slot for
  // the credit check, which is what allows one instruction per cycle with a
  // two-entry queue and single-cycle memory.
  assign w_valid    = (cnt_q != '0);
  assign w_pop      = w_valid && !StallD && !PCSrcE;
  assign w_rsp_keep = imem_rvalid && (disc_q == '0);
  assign w_push     = w_rsp_keep && !PCSrcE;
  assign w_inflight = SW'(cnt_q) - SW'(w_pop) + SW'(outst_q) + SW'(disc_q);
  assign w_credit   = (w_inflight < SW'(FQ_DEPTH));

  assign imem_req   = !rst && !PCSrcE && w_credit && !w_misalign;
  assign imem_addr  = pc_q;
  assign w_issue    = imem_req && imem_gnt;

  // PC, return-PC tracker, outstanding and discard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ret_pc_q <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
    end else if (PCSrcE) begin
      // Everything in flight becomes a discard; a return arriving now is
      // already dropped and so is not counted again.
      pc_q     <= w_tgt;
      ret_pc_q <= w_tgt;
      outst_q  <= '0;
      disc_q   <= disc_q + outst_q - CW'(imem_rvalid);
    end else begin
      if (w_issue) begin
        pc_q <= pc_q + 32'd4;
      end
      if (w_push) begin
        ret_pc_q <= ret_pc_q + 32'd4;
      end
      outst_q <= outst_q + CW'(w_issue) - CW'(w_rsp_keep);
      if (imem_rvalid && (disc_q != '0)) begin
        disc_q <= disc_q - CW'(1);
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (PCSrcE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fq_instr_q[wr_ptr_q] <= imem_rdata;
      fq_pc_q[wr_ptr_q]    <= ret_pc_q;
    end
  end

  // Decode-facing view of the head entry, NOP and PC 0 when empty.
  always_comb begin
    pcd_d = 32'h0000_0000;
    if (w_valid) begin
      pcd_d = fq_pc_q[rd_ptr_q];
    end
  end

  assign ValidD   = w_valid;
  assign InstrD   = w_valid ? fq_instr_q[rd_ptr_q] : NOP;
  assign PCD      = pcd_d;
  assign PCPlus4D = pcd_d + 32'd4;

endmodule
`default_nettype wire
